// File: rtl/csr_commit_ctrl.sv
// Commit-stage controller for SYSTEM instructions: CSR read-modify-write,
// xRET, WFI, SFENCE.VMA and illegal-op exceptions, with kill and async reset.
module csr_commit_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            commit_valid_i,
  input  logic [3:0]      commit_op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [11:0]     csr_addr_i,
  output logic            busy_o,
  output logic            commit_ack_o,
  output logic            csr_req_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic            csr_ready_i,
  input  logic            csr_error_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            eret_o,
  output logic [1:0]      eret_kind_o,
  output logic            flush_req_o,
  input  logic            flush_ack_i,
  input  logic            irq_pending_i,
  input  logic            debug_req_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_cause_o,
  input  logic            kill_i,
  output logic [2:0]      dbg_state_o
);

  // Handshakes: csr_req_o is held with stable address/data until a cycle with
  // csr_ready_i=1; flush_req_o likewise until flush_ack_i=1. Both complete in
  // the cycle the response is seen.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_DONE  = 3'd3,
    S_RET   = 3'd4,
    S_WFI   = 3'd5,
    S_FENCE = 3'd6,
    S_EXC   = 3'd7
  } state_t;

  localparam logic [3:0] OP_READ  = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_SET   = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;

  state_t          state, state_nxt;
  logic [3:0]      op_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] old_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q   <= '0;
      op1_q  <= '0;
      addr_q <= '0;
      old_q  <= '0;
    end else if (!kill_i) begin
      if (state == S_IDLE && commit_valid_i) begin
        op_q   <= commit_op_i;
        op1_q  <= operand1_i;
        addr_q <= csr_addr_i;
      end
      if (state == S_RD && csr_ready_i && !csr_error_i) old_q <= csr_rdata_i;
    end
  end

  always_comb begin
    state_nxt = state;
    if (kill_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (commit_valid_i) begin
          if (commit_op_i <= 4'd3)      state_nxt = S_RD;
          else if (commit_op_i <= 4'd6) state_nxt = S_RET;
          else if (commit_op_i == 4'd7) state_nxt = S_WFI;
          else if (commit_op_i == 4'd8) state_nxt = S_FENCE;
          else                          state_nxt = S_EXC;
        end
        S_RD: if (csr_ready_i) begin
          if (csr_error_i)           state_nxt = S_EXC;
          else if (op_q == OP_READ)  state_nxt = S_DONE;
          else                       state_nxt = S_WR;
        end
        S_WR:    if (csr_ready_i) state_nxt = csr_error_i ? S_EXC : S_DONE;
        S_WFI:   if (irq_pending_i || debug_req_i) state_nxt = S_IDLE;
        S_FENCE: if (flush_ack_i) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (op_q)
      OP_WRITE: wdata = op1_q;
      OP_SET:   wdata = old_q | op1_q;
      OP_CLEAR: wdata = old_q & ~op1_q;
      default:  wdata = old_q;
    endcase
  end

  always_comb begin
    commit_ack_o = 1'b0;
    csr_req_o    = 1'b0;
    csr_we_o     = 1'b0;
    csr_addr_o   = '0;
    csr_wdata_o  = '0;
    wb_valid_o   = 1'b0;
    wb_data_o    = '0;
    eret_o       = 1'b0;
    eret_kind_o  = 2'd0;
    flush_req_o  = 1'b0;
    ex_valid_o   = 1'b0;
    ex_cause_o   = '0;
    if (!kill_i) begin
      case (state)
        S_RD: begin
          csr_req_o  = 1'b1;
          csr_addr_o = addr_q;
        end
        S_WR: begin
          csr_req_o   = 1'b1;
          csr_we_o    = 1'b1;
          csr_addr_o  = addr_q;
          csr_wdata_o = wdata;
        end
        S_DONE: begin
          commit_ack_o = 1'b1;
          wb_valid_o   = 1'b1;
          wb_data_o    = old_q;
        end
        S_RET: begin
          commit_ack_o = 1'b1;
          eret_o       = 1'b1;
          eret_kind_o  = op_q[1:0];  // 4/5/6 map to kinds 0/1/2
        end
        S_WFI: commit_ack_o = irq_pending_i || debug_req_i;
        S_FENCE: begin
          flush_req_o  = 1'b1;
          commit_ack_o = flush_ack_i;
        end
        S_EXC: begin
          commit_ack_o = 1'b1;
          ex_valid_o   = 1'b1;
          ex_cause_o   = XLEN'(2);
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state != S_IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: vector table run through a scoreboard, plus
// hand-written kill / reset / ignored-commit sequences.
module tb_csr_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid;
  logic [3:0]  commit_op;
  logic [63:0] operand1;
  logic [11:0] csr_addr_in;
  logic        busy, commit_ack, csr_req, csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        csr_ready, csr_error;
  logic [63:0] csr_rdata;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic        eret;
  logic [1:0]  eret_kind;
  logic        flush_req, flush_ack, irq_pending, debug_req;
  logic        ex_valid;
  logic [63:0] ex_cause;
  logic        kill;
  logic [2:0]  dbg_state;

  csr_commit_ctrl #(.XLEN(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .commit_valid_i(commit_valid),
    .commit_op_i(commit_op), .operand1_i(operand1), .csr_addr_i(csr_addr_in),
    .busy_o(busy), .commit_ack_o(commit_ack), .csr_req_o(csr_req),
    .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .csr_ready_i(csr_ready), .csr_error_i(csr_error), .csr_rdata_i(csr_rdata),
    .wb_valid_o(wb_valid), .wb_data_o(wb_data), .eret_o(eret),
    .eret_kind_o(eret_kind), .flush_req_o(flush_req), .flush_ack_i(flush_ack),
    .irq_pending_i(irq_pending), .debug_req_i(debug_req),
    .ex_valid_o(ex_valid), .ex_cause_o(ex_cause), .kill_i(kill),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Responder: read phase stalls cur_delay cycles; wake/flush-ack appear once
  // cyc (cycles since acceptance) reaches cur_wake.
  logic [63:0] cur_rdata;
  logic        cur_err, use_dbg;
  int          cur_delay, cur_wake, cyc, rd_cnt;

  assign csr_ready   = csr_req && (csr_we || rd_cnt >= cur_delay);
  assign csr_error   = csr_ready && cur_err && !csr_we;
  assign csr_rdata   = csr_ready ? cur_rdata : 64'd0;
  assign irq_pending = !use_dbg && (cyc >= cur_wake);
  assign debug_req   = use_dbg && (cyc >= cur_wake);
  assign flush_ack   = flush_req && (cyc >= cur_wake);

  always @(posedge clk) begin
    if (csr_req && !csr_we && !csr_ready) rd_cnt <= rd_cnt + 1;
    else                                  rd_cnt <= 0;
  end

  typedef struct {
    logic [3:0]  op;
    logic [63:0] op1;
    logic [11:0] addr;
    logic [63:0] rdata;
    logic        err;
    int          delay;
    int          wake;
    logic        dbg;
    int          lat;
    logic        wb;
    logic [63:0] wb_data;
    logic        ex;
    logic        eret;
    logic [1:0]  kind;
    logic        wr;
    logic [63:0] wdata;
    int          rd_cyc;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [63:0] op1,
                              input logic [11:0] addr, input logic [63:0] rdata,
                              input logic err, input int delay, input int wake,
                              input logic dbg, input int lat, input logic wb,
                              input logic ex, input logic er, input logic [1:0] kind,
                              input logic wr, input logic [63:0] wdata, input int rd_cyc);
    vec_t v;
    v.op = op; v.op1 = op1; v.addr = addr; v.rdata = rdata; v.err = err;
    v.delay = delay; v.wake = wake; v.dbg = dbg; v.lat = lat; v.wb = wb;
    v.wb_data = wb ? rdata : 64'd0; v.ex = ex; v.eret = er; v.kind = kind;
    v.wr = wr; v.wdata = wdata; v.rd_cyc = rd_cyc;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat = 0, rd_cyc = 0;
    logic got_ack = 1'b0, wr_seen = 1'b0, stable = 1'b1;
    logic [63:0] wdata_seen = 64'd0, wbd = 64'd0, exc = 64'd0;
    logic wbv = 1'b0, exv = 1'b0, erv = 1'b0;
    logic [1:0] knd = 2'd0;
    logic [11:0] addr0 = 12'd0;
    vec_t e;
    cur_rdata = v.rdata; cur_err = v.err; cur_delay = v.delay;
    cur_wake = v.wake; use_dbg = v.dbg; cyc = 0;
    exp_q.push_back(v);
    @(negedge clk);
    commit_valid = 1'b1; commit_op = v.op; operand1 = v.op1; csr_addr_in = v.addr;
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_op = 4'($urandom_range(0, 15));
    operand1 = {$urandom, $urandom}; csr_addr_in = 12'($urandom);
    cyc = 1;
    for (int k = 0; k < 40 && !got_ack; k++) begin
      @(negedge clk);
      if (csr_req && !csr_we) begin
        if (rd_cyc == 0) addr0 = csr_addr;
        else if (csr_addr !== addr0) stable = 1'b0;
        rd_cyc++;
      end
      if (csr_req && csr_we) begin wr_seen = 1'b1; wdata_seen = csr_wdata; end
      if (commit_ack) begin
        got_ack = 1'b1; lat = cyc; wbv = wb_valid; wbd = wb_data;
        exv = ex_valid; exc = ex_cause; erv = eret; knd = eret_kind;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    e = exp_q.pop_front();
    chk($sformatf("ack_seen op%0d", e.op), 64'(got_ack), 64'd1);
    if (got_ack) begin
      chk($sformatf("latency op%0d", e.op), 64'(lat), 64'(e.lat));
      chk($sformatf("wb_valid op%0d", e.op), 64'(wbv), 64'(e.wb));
      chk($sformatf("wb_data op%0d", e.op), wbd, e.wb_data);
      chk($sformatf("ex_valid op%0d", e.op), 64'(exv), 64'(e.ex));
      chk($sformatf("ex_cause op%0d", e.op), exc, e.ex ? 64'd2 : 64'd0);
      chk($sformatf("eret op%0d", e.op), 64'(erv), 64'(e.eret));
      chk($sformatf("eret_kind op%0d", e.op), 64'(knd), 64'(e.kind));
    end
    chk($sformatf("wr_access op%0d", e.op), 64'(wr_seen), 64'(e.wr));
    if (e.wr) chk($sformatf("wdata op%0d", e.op), wdata_seen, e.wdata);
    chk($sformatf("rd_cycles op%0d", e.op), 64'(rd_cyc), 64'(e.rd_cyc));
    if (rd_cyc > 0) begin
      chk($sformatf("rd_addr op%0d", e.op), 64'(addr0), 64'(e.addr));
      chk($sformatf("rd_stable op%0d", e.op), 64'(stable), 64'd1);
    end
    @(posedge clk); #1; cyc++;
    @(negedge clk);
    chk($sformatf("post_ack_idle op%0d", e.op), {62'd0, commit_ack, busy}, 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [63:0] r_op1, r_rd;
    logic [3:0]  r_op;
    int          r_dly, seen;
    rst_n = 1'b0; commit_valid = 1'b0; commit_op = 4'd0; operand1 = 64'd0;
    csr_addr_in = 12'd0; kill = 1'b0; cur_rdata = 64'd0; cur_err = 1'b0;
    use_dbg = 1'b0; cur_delay = 0; cur_wake = 1000; cyc = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst ack", 64'(commit_ack), 64'd0);
    chk("rst req_we", {62'd0, csr_req, csr_we}, 64'd0);
    chk("rst addr", 64'(csr_addr), 64'd0);
    chk("rst wdata", csr_wdata, 64'd0);
    chk("rst wb", {63'd0, wb_valid} | wb_data, 64'd0);
    chk("rst eret", {61'd0, eret, eret_kind}, 64'd0);
    chk("rst flush", 64'(flush_req), 64'd0);
    chk("rst ex", {63'd0, ex_valid} | ex_cause, 64'd0);
    chk("rst state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    //         op  op1      addr     rdata    err dly wake dbg lat wb ex er kind wr wdata    rd
    vecs.push_back(mk(0, 64'h0,    12'h300, 64'h1234, 0, 0, 1000, 0, 2, 1, 0, 0, 0, 0, 64'h0,    1));
    vecs.push_back(mk(2, 64'h8,    12'h300, 64'h1800, 0, 0, 1000, 0, 3, 1, 0, 0, 0, 1, 64'h1808, 1));
    vecs.push_back(mk(3, 64'hF,    12'h341, 64'hFF,   0, 3, 1000, 0, 6, 1, 0, 0, 0, 1, 64'hF0,   4));
    vecs.push_back(mk(1, 64'hAB,   12'h305, 64'h77,   1, 0, 1000, 0, 2, 0, 1, 0, 0, 0, 64'h0,    1));
    vecs.push_back(mk(1, 64'hDEAD, 12'h340, 64'h55,   0, 0, 1000, 0, 3, 1, 0, 0, 0, 1, 64'hDEAD, 1));
    vecs.push_back(mk(2, 64'h0,    12'h344, 64'h7,    0, 0, 1000, 0, 3, 1, 0, 0, 0, 1, 64'h7,    1));
    vecs.push_back(mk(3, 64'h0,    12'h344, 64'h9,    0, 0, 1000, 0, 3, 1, 0, 0, 0, 1, 64'h9,    1));
    vecs.push_back(mk(4, 64'h0,    12'h000, 64'h0,    0, 0, 1000, 0, 1, 0, 0, 1, 0, 0, 64'h0,    0));
    vecs.push_back(mk(5, 64'h0,    12'h000, 64'h0,    0, 0, 1000, 0, 1, 0, 0, 1, 1, 0, 64'h0,    0));
    vecs.push_back(mk(6, 64'h0,    12'h000, 64'h0,    0, 0, 1000, 0, 1, 0, 0, 1, 2, 0, 64'h0,    0));
    vecs.push_back(mk(7, 64'h0,    12'h000, 64'h0,    0, 0, 6,    0, 6, 0, 0, 0, 0, 0, 64'h0,    0));
    vecs.push_back(mk(7, 64'h0,    12'h000, 64'h0,    0, 0, 0,    0, 1, 0, 0, 0, 0, 0, 64'h0,    0));
    vecs.push_back(mk(7, 64'h0,    12'h000, 64'h0,    0, 0, 3,    1, 3, 0, 0, 0, 0, 0, 64'h0,    0));
    vecs.push_back(mk(8, 64'h0,    12'h000, 64'h0,    0, 0, 4,    0, 4, 0, 0, 0, 0, 0, 64'h0,    0));
    vecs.push_back(mk(12, 64'h0,   12'h000, 64'h0,    0, 0, 1000, 0, 1, 0, 1, 0, 0, 0, 64'h0,    0));
    vecs.push_back(mk(9, 64'h0,    12'h000, 64'h0,    0, 0, 1000, 0, 1, 0, 1, 0, 0, 0, 64'h0,    0));
    vecs.push_back(mk(15, 64'h0,   12'h000, 64'h0,    0, 0, 1000, 0, 1, 0, 1, 0, 0, 0, 64'h0,    0));
    for (int i = 0; i < 4; i++) begin
      r_op  = 4'($urandom_range(1, 3));
      r_op1 = {$urandom, $urandom};
      r_rd  = {$urandom, $urandom};
      r_dly = $urandom_range(0, 2);
      v = mk(r_op, r_op1, 12'($urandom), r_rd, 0, r_dly, 1000, 0, 3 + r_dly, 1, 0, 0, 0, 1,
             (r_op == 4'd1) ? r_op1 : (r_op == 4'd2) ? (r_rd | r_op1) : (r_rd & ~r_op1),
             r_dly + 1);
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_vec(vecs[i]);

    // Kill during WR: no write, no ack, no writeback; then a fresh commit works
    cur_rdata = 64'h11; cur_err = 1'b0; cur_delay = 0; cur_wake = 1000; cyc = 0;
    @(negedge clk);
    commit_valid = 1'b1; commit_op = 4'd1; operand1 = 64'hABC; csr_addr_in = 12'h340;
    @(posedge clk); #1; commit_valid = 1'b0;
    @(posedge clk); #1; kill = 1'b1;
    @(negedge clk);
    chk("kill_wr state", 64'(dbg_state), 64'd2);
    chk("kill_wr req", {62'd0, csr_req, csr_we}, 64'd0);
    chk("kill_wr ack", {62'd0, commit_ack, wb_valid}, 64'd0);
    @(posedge clk); #1; kill = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || commit_ack || csr_req) seen++;
    end
    chk("kill_wr idle_after", 64'(seen), 64'd0);
    run_vec(mk(0, 64'h0, 12'h342, 64'h5A5A, 0, 0, 1000, 0, 2, 1, 0, 0, 0, 0, 64'h0, 1));

    // kill_i alongside commit_valid in IDLE: not accepted
    @(negedge clk);
    commit_valid = 1'b1; commit_op = 4'd0; kill = 1'b1;
    @(posedge clk); #1; commit_valid = 1'b0; kill = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || commit_ack || csr_req) seen++;
    end
    chk("kill_idle not_accepted", 64'(seen), 64'd0);

    // Reset during FENCE drops flush_req immediately, no ack afterwards
    cur_wake = 1000; cyc = 0;
    @(negedge clk);
    commit_valid = 1'b1; commit_op = 4'd8;
    @(posedge clk); #1; commit_valid = 1'b0;
    @(negedge clk);
    chk("fence flush_req", 64'(flush_req), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_fence flush_req", 64'(flush_req), 64'd0);
    chk("rst_fence busy_ack", {62'd0, busy, commit_ack}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || commit_ack || flush_req) seen++;
    end
    chk("rst_fence quiet", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
